counter_seq_ctrl: RTL and testbench

//   Programmable sequencer around a WIDTH-bit count register (the 3-bit Q2..Q0 counter datapath).

---
 rtl/counter_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - start/end/pass sequencer around a count register; optional irq via COUNTER_SEQ_IRQ_EN
module counter_seq_ctrl #(
  parameter int WIDTH  = 3,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              dir,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [WIDTH-1:0]  end_val,
  input  logic [PASS_W-1:0] passes,
`ifdef COUNTER_SEQ_IRQ_EN
  input  logic              irq_clr,
  output logic              irq,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  // configuration captured on an accepted start
  logic              dir_q;
  logic [WIDTH-1:0]  start_q;
  logic [WIDTH-1:0]  end_q;
  logic [PASS_W-1:0] passes_q;

  logic [WIDTH-1:0]  count_nxt;
  logic [PASS_W-1:0] pass_nxt;
  logic [PASS_W-1:0] pass_inc;
  logic [PASS_W-1:0] passes_eff;
  logic              cfg_ld;

  assign pass_inc   = pass_cnt + 1'b1;
  // a programmed pass count of zero still runs one pass
  assign passes_eff = (passes_q == '0) ? {{(PASS_W-1){1'b0}}, 1'b1} : passes_q;

  // next state and next datapath values; RUN priority is abort > pause > end-match > step
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pass_nxt  = pass_cnt;
    cfg_ld    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cfg_ld    = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          count_nxt = start_q;
          pass_nxt  = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (pause) begin
          // everything holds while paused
          state_nxt = S_RUN;
        end else if (count == end_q) begin
          pass_nxt = pass_inc;
          if (pass_inc == passes_eff) begin
            state_nxt = S_DONE;
          end else begin
            // next pass restarts directly, no LOAD cycle in between
            count_nxt = start_q;
          end
        end else begin
          count_nxt = dir_q ? count + 1'b1 : count - 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // configuration latch, loaded only when a start is accepted in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q    <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      passes_q <= '0;
    end else if (cfg_ld) begin
      dir_q    <= dir;
      start_q  <= start_val;
      end_q    <= end_val;
      passes_q <= passes;
    end
  end

  // registered outputs; busy/done derive from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      pass_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      count    <= count_nxt;
      pass_cnt <= pass_nxt;
      busy     <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
      done     <= (state_nxt == S_DONE);
    end
  end

`ifdef COUNTER_SEQ_IRQ_EN
  // sticky completion flag, set on the DONE->IDLE edge; set beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else if (state == S_DONE) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - scoreboard bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, pause, dir;
  logic [2:0] start_val, end_val;
  logic [3:0] passes;
  logic [2:0] count;
  logic       busy, done;
  logic [3:0] pass_cnt;
`ifdef COUNTER_SEQ_IRQ_EN
  logic       irq_clr, irq;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause), .dir(dir),
    .start_val(start_val), .end_val(end_val), .passes(passes),
`ifdef COUNTER_SEQ_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .count(count), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  // one scoreboard entry: stimulus for an edge plus the outputs expected after it
  typedef struct packed {
    logic [2:0] c;
    logic       b;
    logic       d;
    logic [3:0] p;
    logic       pz;
    logic       ab;
    logic       st;
    logic       ld;
    logic       cd;
    logic [2:0] csv;
    logic [2:0] cev;
    logic [3:0] cps;
  } ent_t;

  ent_t       exp_q[$];
  logic [2:0] m_count;
  logic [3:0] m_pass;

  task automatic push(input logic [2:0] c, input logic b, input logic d, input logic [3:0] p,
                      input logic pz, input logic ab, input logic st, input logic ld,
                      input logic cd, input logic [2:0] csv, input logic [2:0] cev,
                      input logic [3:0] cps);
    ent_t e;
    e.c = c; e.b = b; e.d = d; e.p = p; e.pz = pz; e.ab = ab; e.st = st; e.ld = ld;
    e.cd = cd; e.csv = csv; e.cev = cev; e.cps = cps;
    exp_q.push_back(e);
  endtask

  // expected trace from the timing rules: LOAD, P passes of d+1 counts, DONE, IDLE
  task automatic build_seq(input logic dr, input logic [2:0] sv, input logic [2:0] ev,
                           input logic [3:0] ps, input int pause_val, input int pause_len,
                           input int stop_after);
    logic [2:0] dd, c;
    int np, n;
    dd = dr ? ev - sv : sv - ev;
    np = (ps == 4'd0) ? 1 : int'(ps);
    push(m_count, 1'b1, 1'b0, m_pass, 1'b0, 1'b0, 1'b1, 1'b1, dr, sv, ev, ps);
    n = 0;
    for (int p = 0; p < np; p++) begin
      for (int k = 0; k <= int'(dd); k++) begin
        c = dr ? sv + 3'(k) : sv - 3'(k);
        push(c, 1'b1, 1'b0, 4'(p), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
        n++;
        if (p == 0 && int'(c) == pause_val)
          for (int j = 0; j < pause_len; j++)
            push(c, 1'b1, 1'b0, 4'(p), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
        if (n == stop_after) begin
          m_count = c;
          m_pass  = 4'(p);
          return;
        end
      end
    end
    push(ev, 1'b0, 1'b1, 4'(np), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    push(ev, 1'b0, 1'b0, 4'(np), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    m_count = ev;
    m_pass  = 4'(np);
  endtask

  task automatic push_idle(input int n, input logic ab);
    for (int i = 0; i < n; i++)
      push(m_count, 1'b0, 1'b0, m_pass, 1'b0, ab, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
  endtask

  // drain the scoreboard: drive each entry, clock once, compare
  task automatic run_q(input string name);
    ent_t e;
    int   step;
    step = 0;
    while (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      start = e.st;
      pause = e.pz;
      abort = e.ab;
      if (e.ld) begin
        dir = e.cd; start_val = e.csv; end_val = e.cev; passes = e.cps;
      end
      @(posedge clk);
      #1;
      start = 1'b0; pause = 1'b0; abort = 1'b0;
      dir = 1'($urandom); start_val = 3'($urandom); end_val = 3'($urandom);
      passes = 4'($urandom);
      total++;
      if (count !== e.c || busy !== e.b || done !== e.d || pass_cnt !== e.p)
        $display("FAIL %s step %0d: got count=%0d busy=%b done=%b pass_cnt=%0d, want count=%0d busy=%b done=%b pass_cnt=%0d",
                 name, step, count, busy, done, pass_cnt, e.c, e.b, e.d, e.p);
      else
        passed++;
      step++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; dir = 1'b0;
    start_val = 3'd0; end_val = 3'd0; passes = 4'd0;
`ifdef COUNTER_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 4'd0)
      $display("FAIL reset_state: got count=%0d busy=%b done=%b pass_cnt=%0d, want 0 0 0 0",
               count, busy, done, pass_cnt);
    else
      passed++;
    @(negedge clk);
    rst = 1'b1;
    m_count = 3'd0;
    m_pass  = 4'd0;
    push_idle(2, 1'b1);
    run_q("idle_after_reset");
  endtask

  task automatic test_up_multi();
    build_seq(1'b1, 3'd2, 3'd5, 4'd2, -1, 0, 0);
    run_q("up_multi");
  endtask

  task automatic test_down_wrap();
    build_seq(1'b0, 3'd1, 3'd6, 4'd1, -1, 0, 0);
    run_q("down_wrap");
  endtask

  task automatic test_pause();
    build_seq(1'b1, 3'd2, 3'd5, 4'd2, 4, 3, 0);
    run_q("pause");
  endtask

  task automatic test_abort();
    ent_t e;
    build_seq(1'b1, 3'd2, 3'd6, 4'd1, -1, 0, 2);
    e = exp_q[2];
    e.st = 1'b1;
    exp_q[2] = e;
    push(3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    m_count = 3'd3;
    m_pass  = 4'd0;
    push_idle(2, 1'b1);
    push(3'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 3'd6, 4'd1);
    push(3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    push_idle(1, 1'b0);
    run_q("abort");
  endtask

  task automatic test_edge_passes0();
    build_seq(1'b1, 3'd7, 3'd7, 4'd0, -1, 0, 0);
    run_q("passes0_same_val");
`ifdef COUNTER_SEQ_IRQ_EN
    total++;
    if (irq !== 1'b1) $display("FAIL irq_set: got irq=%b, want 1", irq);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (irq !== 1'b1) $display("FAIL irq_sticky: got irq=%b, want 1", irq);
    else passed++;
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clr: got irq=%b, want 0", irq);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    ent_t e;
    build_seq(1'b0, 3'd3, 3'd3, 4'd2, -1, 0, 0);
    e = exp_q[exp_q.size() - 1];
    e.st = 1'b1;
    exp_q[exp_q.size() - 1] = e;
    build_seq(1'b0, 3'd0, 3'd6, 4'd1, -1, 0, 0);
    run_q("back_to_back");
  endtask

  task automatic test_reset_midrun();
    build_seq(1'b1, 3'd0, 3'd7, 4'd1, -1, 0, 6);
    run_q("run_to_5");
    rst = 1'b0;
    #2;
    total++;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 4'd0)
      $display("FAIL async_reset: got count=%0d busy=%b done=%b pass_cnt=%0d, want 0 0 0 0",
               count, busy, done, pass_cnt);
    else
      passed++;
    @(negedge clk);
    rst = 1'b1;
    m_count = 3'd0;
    m_pass  = 4'd0;
    push_idle(2, 1'b0);
    run_q("idle_after_midrun_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_up_multi();
    test_down_wrap();
    test_pause();
    test_abort();
    test_edge_passes0();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
